// File: rtl/md_ctrl_pkg.sv
// Shared pipeline definitions for the multiply/divide controller:
// operation codes, state encoding, latency constants and small helpers.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  // Codes 0-3 occupy the unit for several cycles; everything else is single-edge.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  // Two's-complement negate when the flag is set, pass through otherwise.
  function automatic logic [31:0] md_cneg(input logic neg, input logic [31:0] val);
    logic [31:0] res;
    if (neg) begin
      res = 32'd0 - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/md_ctrl.sv
// Multiply/divide controller: computes results at issue into shadow registers,
// then holds Busy for the fixed latency before committing them to HI/LO.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic        flush,
  input  logic        MD_D,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state_r;
  md_state_e   state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic        busy_r;
  logic        busy_s;
  logic [31:0] hi_r;
  logic [31:0] hi_s;
  logic [31:0] lo_r;
  logic [31:0] lo_s;
  logic [31:0] sh_hi_r;
  logic [31:0] sh_hi_s;
  logic [31:0] sh_lo_r;
  logic [31:0] sh_lo_s;
  logic        sh_ok_r;
  logic        sh_ok_s;

  logic        accept_s;
  logic        mul_signed_s;
  logic        div_signed_s;
  logic [63:0] prod_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_safe_s;
  logic        div_zero_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  assign accept_s     = start & ~flush & (state_r == MD_IDLE);
  assign mul_signed_s = (MDop == MD_MULT);
  assign div_signed_s = (MDop == MD_DIV);

  // Sign-extending both operands to 64 bits makes one unsigned multiplier serve both forms.
  assign prod_s = {{32{mul_signed_s & DataA[31]}}, DataA} * {{32{mul_signed_s & DataB[31]}}, DataB};

  // Magnitude division; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign a_neg_s    = div_signed_s & DataA[31];
  assign b_neg_s    = div_signed_s & DataB[31];
  assign a_mag_s    = md_cneg(a_neg_s, DataA);
  assign b_mag_s    = md_cneg(b_neg_s, DataB);
  assign div_zero_s = (DataB == 32'd0);
  assign b_safe_s   = div_zero_s ? 32'd1 : b_mag_s;
  assign q_mag_s    = a_mag_s / b_safe_s;
  assign r_mag_s    = a_mag_s % b_safe_s;
  assign quo_s      = md_cneg(a_neg_s ^ b_neg_s, q_mag_s);
  assign rem_s      = md_cneg(a_neg_s, r_mag_s);

  // Next-state, counter, shadow and architectural register updates.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    sh_hi_s = sh_hi_r;
    sh_lo_s = sh_lo_r;
    sh_ok_s = sh_ok_r;
    case (state_r)
      MD_IDLE: begin
        if (accept_s) begin
          case (MDop)
            MD_MULT, MD_MULTU: begin
              sh_hi_s = prod_s[63:32];
              sh_lo_s = prod_s[31:0];
              sh_ok_s = 1'b1;
              state_s = MD_RUN;
              cnt_s   = MD_MULT_CYC;
              busy_s  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              sh_hi_s = rem_s;
              sh_lo_s = quo_s;
              sh_ok_s = ~div_zero_s;
              state_s = MD_RUN;
              cnt_s   = MD_DIV_CYC;
              busy_s  = 1'b1;
            end
            MD_MTHI: begin
              hi_s = DataA;
            end
            MD_MTLO: begin
              lo_s = DataA;
            end
            default: begin
              state_s = MD_IDLE;
            end
          endcase
        end else begin
          state_s = MD_IDLE;
        end
      end
      MD_RUN: begin
        if (cnt_r <= 4'd1) begin
          state_s = MD_IDLE;
          cnt_s   = 4'd0;
          busy_s  = 1'b0;
          if (sh_ok_r) begin
            hi_s = sh_hi_r;
            lo_s = sh_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = MD_IDLE;
        cnt_s   = 4'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counter and data registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= MD_IDLE;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      sh_hi_r <= 32'd0;
      sh_lo_r <= 32'd0;
      sh_ok_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      sh_hi_r <= sh_hi_s;
      sh_lo_r <= sh_lo_s;
      sh_ok_r <= sh_ok_s;
    end
  end

  assign Busy     = busy_r;
  assign HI       = hi_r;
  assign LO       = lo_r;
  // Gated by reset so the front end never freezes while the unit is being cleared.
  assign Stall_MD = MD_D & ~reset & (busy_r | (start & ~flush & md_is_long(MDop)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vector table, hand-written corner
// sequences, and randomized operations checked against an arithmetic model.
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDop;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        flush;
  logic        MD_D;
  logic        Busy;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[15];

  md_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop),
    .DataA(DataA), .DataB(DataB), .flush(flush), .MD_D(MD_D),
    .Busy(Busy), .Stall_MD(Stall_MD), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result of one operation computed from the architectural rules with 64-bit arithmetic.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h_in, input logic [31:0] l_in,
                                   output logic [3:0] cyc, output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p, uq, ur;
    h = h_in;
    l = l_in;
    cyc = 4'd0;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        h = p[63:32]; l = p[31:0]; cyc = 4'd5;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32]; l = p[31:0]; cyc = 4'd5;
      end
      3'd2: begin
        cyc = 4'd10;
        if (b != 32'd0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end
      end
      3'd3: begin
        cyc = 4'd10;
        if (b != 32'd0) begin
          uq = {32'd0, a} / {32'd0, b};
          ur = {32'd0, a} % {32'd0, b};
          l = uq[31:0]; h = ur[31:0];
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: cyc = 4'd0;
    endcase
  endfunction

  // Issue one operation from posedge+1, follow it to completion, check timing, stall and result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic md, input logic [3:0] exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    cyc = 0;
    start = 1'b1; MDop = op; DataA = a; DataB = b; flush = 1'b0; MD_D = md;
    #1;
    check({name, " stall_issue"}, {63'd0, Stall_MD}, {63'd0, md & (op <= 3'd3)});
    @(posedge clk); #1;
    start = 1'b0; DataA = $urandom; DataB = $urandom;
    while (Busy === 1'b1 && cyc < 20) begin
      cyc++;
      check({name, " stall_busy"}, {63'd0, Stall_MD}, {63'd0, md});
      @(posedge clk); #1;
    end
    check({name, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({name, " stall_after"}, {63'd0, Stall_MD}, 64'd0);
    check({name, " hi"}, {32'd0, HI}, {32'd0, exp_hi});
    check({name, " lo"}, {32'd0, LO}, {32'd0, exp_lo});
  endtask

  initial begin
    int cyc;
    logic [3:0]  e_cyc;
    logic [31:0] e_hi, e_lo, rb, ra;
    logic [2:0]  rop;
    logic        rmd;
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b1; MDop = 3'd0; DataA = 32'd5; DataB = 32'd6; flush = 1'b0; MD_D = 1'b1;

    vecs[0]  = '{3'd4, 32'h11,       32'h0,        4'd0,  32'h11,       32'h0};
    vecs[1]  = '{3'd5, 32'h22,       32'h0,        4'd0,  32'h11,       32'h22};
    vecs[2]  = '{3'd2, 32'h5,        32'h0,        4'd10, 32'h11,       32'h22};
    vecs[3]  = '{3'd3, 32'h9,        32'h0,        4'd10, 32'h11,       32'h22};
    vecs[4]  = '{3'd0, 32'hFFFFFFFF, 32'h2,        4'd5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'h2,        4'd5,  32'h1,        32'hFFFFFFFE};
    vecs[6]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        4'd10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{3'd3, 32'h7,        32'h2,        4'd10, 32'h1,        32'h3};
    vecs[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h0,        32'h80000000};
    vecs[9]  = '{3'd5, 32'h1234,     32'h0,        4'd0,  32'h0,        32'h1234};
    vecs[10] = '{3'd6, 32'h5,        32'h7,        4'd0,  32'h0,        32'h1234};
    vecs[11] = '{3'd2, 32'h7,        32'hFFFFFFFE, 4'd10, 32'h1,        32'hFFFFFFFD};
    vecs[12] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h80000000, 32'h0};
    vecs[13] = '{3'd0, 32'h80000000, 32'h80000000, 4'd5,  32'h40000000, 32'h0};
    vecs[14] = '{3'd4, 32'hDEADBEEF, 32'h0,        4'd0,  32'hDEADBEEF, 32'h0};

    #1;
    check("reset busy",  {63'd0, Busy},     64'd0);
    check("reset stall", {63'd0, Stall_MD}, 64'd0);
    check("reset hi",    {32'd0, HI},       64'd0);
    check("reset lo",    {32'd0, LO},       64'd0);
    @(posedge clk); #1;
    check("reset hold busy", {63'd0, Busy}, 64'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'(i % 2),
             vecs[i].cyc, vecs[i].hi, vecs[i].lo);
    end
    model_hi = 32'hDEADBEEF; model_lo = 32'h0;

    // Start with flush: no stall, no busy, no write.
    start = 1'b1; flush = 1'b1; MD_D = 1'b1; MDop = 3'd0; DataA = 32'd3; DataB = 32'd3;
    #1;
    check("flush stall", {63'd0, Stall_MD}, 64'd0);
    @(posedge clk); #1;
    check("flush busy", {63'd0, Busy}, 64'd0);
    MDop = 3'd5; DataA = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush busy2", {63'd0, Busy}, 64'd0);
    check("flush hi", {32'd0, HI}, {32'd0, model_hi});
    check("flush lo", {32'd0, LO}, {32'd0, model_lo});

    // Start ignored during RUN, flush does not abort a running multiply.
    start = 1'b1; MDop = 3'd0; DataA = 32'd3; DataB = 32'd4; MD_D = 1'b0;
    @(posedge clk); #1;
    MDop = 3'd5; DataA = 32'hDEAD;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 20) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b0; flush = 1'b1;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; start = 1'b0;
    check("run ignore cycles", 64'(cyc), 64'd5);
    check("run ignore hi", {32'd0, HI}, 64'd0);
    check("run ignore lo", {32'd0, LO}, 64'd12);
    model_hi = 32'd0; model_lo = 32'd12;

    // Reset in the third busy cycle of a divide.
    run_op("pre_reset mthi", 3'd4, 32'hAAAA, 32'd0, 1'b0, 4'd0, 32'hAAAA, 32'd12);
    start = 1'b1; MDop = 3'd2; DataA = 32'd100; DataB = 32'd7; MD_D = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun busy before", {63'd0, Busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("midrun reset busy",  {63'd0, Busy},     64'd0);
    check("midrun reset stall", {63'd0, Stall_MD}, 64'd0);
    check("midrun reset hi",    {32'd0, HI},       64'd0);
    check("midrun reset lo",    {32'd0, LO},       64'd0);
    @(posedge clk); #1;
    reset = 1'b0; MD_D = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    check("post reset busy", {63'd0, Busy}, 64'd0);
    check("post reset hi",   {32'd0, HI},   64'd0);
    check("post reset lo",   {32'd0, LO},   64'd0);
    model_hi = 32'd0; model_lo = 32'd0;

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'd0 - 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      rmd = 1'($urandom_range(0, 1));
      model_op(rop, ra, rb, model_hi, model_lo, e_cyc, e_hi, e_lo);
      run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, rmd, e_cyc, e_hi, e_lo);
      model_hi = e_hi; model_lo = e_lo;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: E-stage multiply/divide-class instruction valid this cycle.
REQ-004 SHALL have port MDop, input, 3 bits: operation code per REQ-016.
REQ-005 SHALL have port DataA, input, 32 bits: forwarded rs operand.
REQ-006 SHALL have port DataB, input, 32 bits: forwarded rt operand.
REQ-007 SHALL have port flush, input, 1 bit: exception/ERET clear of the E-stage instruction this cycle.
REQ-008 SHALL have port MD_D, input, 1 bit: D-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo).
REQ-009 SHALL have port Busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port Stall_MD, output, 1 bit: freeze F/D, bubble into E.
REQ-011 SHALL have port HI, output, 32 bits: committed HI register.
REQ-012 SHALL have port LO, output, 32 bits: committed LO register.

Function
REQ-013 SHALL implement two states: IDLE and RUN; a 4-bit down-counter holds the remaining cycles.
REQ-014 SHALL accept start only in IDLE with flush=0; start with flush=1 SHALL have no effect.
REQ-015 SHALL ignore start while in RUN: no state, counter or HI/LO change.
REQ-016 SHALL decode MDop as 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; codes 6-7 SHALL be treated as no-op.
REQ-017 SHALL, on accepted mult/multu, latch the 64-bit product {HI,LO} into shadow registers, enter RUN, and load the counter with 5.
REQ-018 SHALL, on accepted div/divu, latch LO=quotient and HI=remainder into shadow registers, enter RUN, and load the counter with 10.
REQ-019 SHALL hold Busy=1 for exactly 5 (mult) or 10 (div) cycles, beginning the cycle after acceptance.
REQ-020 SHALL copy the shadow registers to HI/LO on the edge ending the last Busy cycle; new values and Busy=0 SHALL appear together in the following cycle.
REQ-021 SHALL, on accepted mthi or mtlo, write DataA to HI or LO respectively on the same edge, with no RUN and no Busy.
REQ-022 SHALL compute signed division truncating toward zero, with the remainder taking the sign of the dividend.
REQ-023 SHALL give 0x80000000 / 0xFFFFFFFF (signed) the result LO=0x80000000, HI=0.
REQ-024 SHALL, when the divisor is 0, still run 10 cycles but leave HI/LO unchanged at commit.
REQ-025 SHALL make Stall_MD combinational: MD_D & (Busy | (start & ~flush & MDop<=3)).
REQ-026 SHALL NOT abort an operation already in RUN on flush; the issuing instruction has already passed E and commits.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-RUN, immediately force IDLE, counter=0, Busy=0, HI=0, LO=0 and clear the shadow registers.
REQ-028 SHALL hold Stall_MD=0 during reset.

Structure
REQ-029 SHALL take the MDop codes and the latency constants MD_MULT_CYC=5 and MD_DIV_CYC=10 from the shared pipeline definitions header used by the controller.
REQ-030 SHALL be a single module with no sub-module; the arithmetic is inline combinational logic feeding the shadow registers.

Verification
REQ-031 SHALL check: mult 0xFFFFFFFF x 2 -> Busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-032 SHALL check: div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 Busy cycles; divu 7/2 -> LO=3, HI=1.
REQ-033 SHALL check: div by 0 with HI=0x11, LO=0x22 -> 10 Busy cycles, HI/LO unchanged; signed 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-034 SHALL check: MD_D=1 while Busy -> Stall_MD=1 every Busy cycle, falling with Busy; MD_D=0 -> Stall_MD=0.
REQ-035 SHALL check: start with flush=1 -> Busy stays 0 and HI/LO unchanged; mtlo 0x1234 -> LO=0x1234 the next cycle with Busy=0.
REQ-036 SHALL check: reset asserted in the 3rd Busy cycle of a div -> Busy=0, HI=LO=0 asynchronously, with no commit after release.
